// File: rtl/reg_writeback_buffer_if.sv
// reg_writeback_buffer_if
//   Bundles the signals of the register-file writeback buffer.
//   - wb_*     : writeback requests from MEM/WB (valid/ready handshake)
//   - rf_*     : drain port toward the register-file write inputs
//   - Rs1/Rs2  : ID-stage read indices; byp*_hit/byp*_data return pending values
//   - count    : number of entries currently held
//   Modports: master = pipeline/register-file side, slave = the buffer itself.
interface reg_writeback_buffer_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            wb_valid;
  logic            wb_ready;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            rf_ready;
  logic            rf_we;
  logic [AW-1:0]   rf_rd;
  logic [XLEN-1:0] rf_wdata;
  logic [AW-1:0]   Rs1;
  logic [AW-1:0]   Rs2;
  logic            byp1_hit;
  logic [XLEN-1:0] byp1_data;
  logic            byp2_hit;
  logic [XLEN-1:0] byp2_data;
  logic [AW:0]     count;

  modport master (
    output wb_valid, wb_rd, wb_data, rf_ready, Rs1, Rs2,
    input  wb_ready, rf_we, rf_rd, rf_wdata, byp1_hit, byp1_data, byp2_hit, byp2_data, count
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data, rf_ready, Rs1, Rs2,
    output wb_ready, rf_we, rf_rd, rf_wdata, byp1_hit, byp1_data, byp2_hit, byp2_data, count
  );
endinterface

// File: rtl/reg_writeback_buffer.sv
// reg_writeback_buffer
//   Write side of the 32x32 integer register file. Writeback requests are queued in a
//   DEPTH-entry FIFO and drained one per cycle into the register-file write port, with a
//   read-bypass lookup so ID-stage reads see values that have not drained yet.
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset (discards all pending entries)
//   bus  : reg_writeback_buffer_if.slave (wb handshake, rf drain port, bypass, count)
// Build option
//   WB_COALESCE_EN : a push whose rd matches a pending non-head entry overwrites that
//                    entry's data in place instead of allocating; such a push is accepted
//                    even when the buffer is full.
//
// state  | meaning
// IDLE   | buffer empty, rf_we low
// DRAIN  | at least one entry pending, head presented on rf_* (FULL = DRAIN with wb_ready low)
module reg_writeback_buffer #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  reg_writeback_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [AW-1:0]   rd_mem   [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  logic [0:0]    state_q, state_d;
  logic          full, accept, pop, alloc, coal, rf_we;
  logic [PW-1:0] b_idx;

  assign full   = (count_q == FULL_CNT);
  assign rf_we  = (state_q == ST_DRAIN);
  assign pop    = rf_we && bus.rf_ready;
  // x0 requests complete the handshake but never enter the buffer
  assign accept = bus.wb_valid && bus.wb_ready && (bus.wb_rd != '0);
  assign alloc  = accept && !coal;

`ifdef WB_COALESCE_EN
  logic          coal_hit;
  logic [PW-1:0] coal_idx, c_idx;

  // Youngest pending match excluding the head; the head may be draining this cycle,
  // so a write to its rd must queue behind it.
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    c_idx    = '0;
    for (int i = 1; i < DEPTH; i++) begin
      c_idx = head_q + PW'(i);
      if (i < int'(count_q) && rd_mem[c_idx] == bus.wb_rd && bus.wb_rd != '0) begin
        coal_hit = 1'b1;
        coal_idx = c_idx;
      end
    end
  end

  assign bus.wb_ready = !full || coal_hit;
  assign coal         = accept && coal_hit;
`else
  assign bus.wb_ready = !full;
  assign coal         = 1'b0;
`endif

  always_comb begin
    head_d  = pop   ? head_q + 1'b1 : head_q;
    tail_d  = alloc ? tail_q + 1'b1 : tail_q;
    count_d = count_q + (PW+1)'(alloc) - (PW+1)'(pop);
    state_d = (count_d != '0) ? ST_DRAIN : ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= ST_IDLE;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  // Entry storage carries no reset; validity is tracked by head/count alone.
  always_ff @(posedge clk) begin
    if (alloc) begin
      rd_mem[tail_q]   <= bus.wb_rd;
      data_mem[tail_q] <= bus.wb_data;
    end
`ifdef WB_COALESCE_EN
    else if (coal) begin
      data_mem[coal_idx] <= bus.wb_data;
    end
`endif
  end

  // Drain port is a pure function of registered state; gated to zero when empty.
  assign bus.rf_we    = rf_we;
  assign bus.rf_rd    = rf_we ? rd_mem[head_q]   : '0;
  assign bus.rf_wdata = rf_we ? data_mem[head_q] : '0;
  assign bus.count    = (AW+1)'(count_q);

  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    bus.byp1_hit  = 1'b0;
    bus.byp1_data = '0;
    bus.byp2_hit  = 1'b0;
    bus.byp2_data = '0;
    b_idx         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      b_idx = head_q + PW'(i);
      if (i < int'(count_q)) begin
        if (bus.Rs1 != '0 && rd_mem[b_idx] == bus.Rs1) begin
          bus.byp1_hit  = 1'b1;
          bus.byp1_data = data_mem[b_idx];
        end
        if (bus.Rs2 != '0 && rd_mem[b_idx] == bus.Rs2) begin
          bus.byp2_hit  = 1'b1;
          bus.byp2_data = data_mem[b_idx];
        end
      end
    end
  end
endmodule

// File: tb/tb_reg_writeback_buffer.sv
// tb_reg_writeback_buffer
//   Self-checking bench for reg_writeback_buffer (default build, DEPTH=4).
//   A negedge monitor keeps a scoreboard of accepted requests and checks every drained
//   write against it in order, along with count/wb_ready/rf_we each cycle. Directed
//   sequences cover reset, single write, fill/stall, bypass, x0 drop, sustained
//   streaming and reset mid-drain.
module tb_reg_writeback_buffer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_writeback_buffer_if #(.XLEN(32), .AW(5)) bus ();

  reg_writeback_buffer #(.XLEN(32), .AW(5), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  ent_t        sb_q[$];
  ent_t        mon_e;
  logic [31:0] golden   [32];
  logic [31:0] captured [32];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] d);
    logic acc;
    acc = 1'b0;
    bus.wb_valid = 1'b1;
    bus.wb_rd    = rd;
    bus.wb_data  = d;
    for (int k = 0; k < 40 && !acc; k++) begin
      acc = bus.wb_ready;
      tick();
    end
    bus.wb_valid = 1'b0;
    check_val("push_accept", acc, 1);
  endtask

  task automatic wait_empty();
    for (int k = 0; k < 40 && bus.count != 0; k++) tick();
    check_val("drain_done", bus.count, 0);
  endtask

  // Scoreboard: state seen here is the pre-edge state; the queue is then updated
  // with what the coming edge pops and pushes.
  always @(negedge clk) begin
    if (!rst) begin
      check_val("count", bus.count, sb_q.size());
      check_val("wb_ready", bus.wb_ready, sb_q.size() != 4);
      check_val("rf_we", bus.rf_we, sb_q.size() != 0);
      if (bus.rf_we && bus.rf_ready) begin
        if (sb_q.size() == 0) begin
          check_val("sb_underrun", bus.rf_we, 0);
        end else begin
          mon_e = sb_q.pop_front();
          check_val("drain_rd", bus.rf_rd, mon_e.rd);
          check_val("drain_data", bus.rf_wdata, mon_e.data);
          captured[bus.rf_rd] = bus.rf_wdata;
        end
      end
      if (bus.wb_valid && bus.wb_ready && bus.wb_rd != 0) begin
        sb_q.push_back({bus.wb_rd, bus.wb_data});
        golden[bus.wb_rd] = bus.wb_data;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < 32; r++) begin
      golden[r]   = '0;
      captured[r] = '0;
    end
    rst          = 1'b1;
    bus.wb_valid = 1'b0;
    bus.wb_rd    = '0;
    bus.wb_data  = '0;
    bus.rf_ready = 1'b0;
    bus.Rs1      = '0;
    bus.Rs2      = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_rf_we", bus.rf_we, 0);
    check_val("rst_count", bus.count, 0);
    check_val("rst_wb_ready", bus.wb_ready, 1);
    check_val("rst_rf_rd", bus.rf_rd, 0);
    check_val("rst_rf_wdata", bus.rf_wdata, 0);
    check_val("rst_byp1_hit", bus.byp1_hit, 0);
    check_val("rst_byp2_hit", bus.byp2_hit, 0);
    rst = 1'b0;

    // single write, one-cycle latency; popping entry still bypasses
    bus.rf_ready = 1'b1;
    bus.Rs1      = 5'd5;
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd5;
    bus.wb_data  = 32'hDEADBEEF;
    #1;
    check_val("no_sameclk_byp", bus.byp1_hit, 0);
    tick();
    bus.wb_valid = 1'b0;
    #1;
    check_val("t2_rf_we", bus.rf_we, 1);
    check_val("t2_rf_rd", bus.rf_rd, 5);
    check_val("t2_rf_wdata", bus.rf_wdata, 32'hDEADBEEF);
    check_val("t2_pop_byp_hit", bus.byp1_hit, 1);
    check_val("t2_pop_byp_data", bus.byp1_data, 32'hDEADBEEF);
    tick();
    check_val("t2_empty_we", bus.rf_we, 0);
    check_val("t2_empty_cnt", bus.count, 0);

    // x0 write is accepted and dropped
    push(5'd0, 32'hFFFFFFFF);
    check_val("x0_count", bus.count, 0);
    check_val("x0_rf_we", bus.rf_we, 0);

    // fill, stall, then drain in order
    bus.rf_ready = 1'b0;
    for (int r = 1; r <= 4; r++) push(5'(r), 32'h100 + 32'(r));
    check_val("full_count", bus.count, 4);
    check_val("full_ready", bus.wb_ready, 0);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd9;
    bus.wb_data  = 32'h909;
    repeat (3) tick();
    check_val("stall_count", bus.count, 4);
    check_val("stall_ready", bus.wb_ready, 0);
    bus.rf_ready = 1'b1;
    push(5'd9, 32'h909);
    wait_empty();

    // bypass: youngest match wins, x0 never hits
    bus.rf_ready = 1'b0;
    push(5'd7, 32'h11);
    push(5'd7, 32'h22);
    push(5'd12, 32'h33);
    bus.Rs1 = 5'd7;
    bus.Rs2 = 5'd0;
    #1;
    check_val("byp1_hit", bus.byp1_hit, 1);
    check_val("byp1_data", bus.byp1_data, 32'h22);
    check_val("byp2_x0_hit", bus.byp2_hit, 0);
    check_val("byp2_x0_data", bus.byp2_data, 0);
    check_val("byp_count", bus.count, 3);
    bus.Rs2 = 5'd12;
    bus.Rs1 = 5'd3;
    #1;
    check_val("byp2_hit", bus.byp2_hit, 1);
    check_val("byp2_data", bus.byp2_data, 32'h33);
    check_val("byp1_miss", bus.byp1_hit, 0);
    bus.rf_ready = 1'b1;
    wait_empty();
    check_val("last_wins_r7", captured[7], 32'h22);

    // sustained push + pop at count 2 with pointer wrap
    bus.rf_ready = 1'b0;
    push(5'd10, $urandom);
    push(5'd11, $urandom);
    bus.rf_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      push(5'(10 + (i % 6)), $urandom);
      check_val("steady_count", bus.count, 2);
    end
    wait_empty();
    for (int r = 10; r < 16; r++) check_val("rf_golden", captured[r], golden[r]);

    // reset mid-drain discards everything immediately
    bus.rf_ready = 1'b0;
    push(5'd20, 32'hA0);
    push(5'd21, 32'hA1);
    push(5'd22, 32'hA2);
    bus.rf_ready = 1'b1;
    bus.Rs1      = 5'd22;
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_val("mid_rst_rf_we", bus.rf_we, 0);
    check_val("mid_rst_count", bus.count, 0);
    check_val("mid_rst_ready", bus.wb_ready, 1);
    check_val("mid_rst_byp", bus.byp1_hit, 0);
    sb_q.delete();
    tick();
    rst = 1'b0;
    tick();
    check_val("post_rst_count", bus.count, 0);
    check_val("post_rst_we", bus.rf_we, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
